// File: rtl/common_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
// Imported by the arbiter FSM and its round-robin picker.
package common_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ACK_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } uart_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr_i,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick
  import common_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int IW = $clog2(N_REQ);

  int unsigned j;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ
// requesters; loads a frame, waits for busy rise then busy fall.
module uart_tx_arbiter
  import common_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_par_en,
  input  logic [N_REQ-1:0]          req_par_typ,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         tx_p_data,
  output logic                      tx_data_valid,
  output logic                      tx_par_en,
  output logic                      tx_par_typ,
  input  logic                      tx_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      arb_busy,
  output logic                      err_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  uart_arb_state_e   state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [N_REQ-1:0]  rdy_q, rdy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pen_q, pen_d;
  logic              ptyp_q, ptyp_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    rdy_d   = '0;
    data_d  = data_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          rdy_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          data_d  = sel_data;
          pen_d   = req_par_en[pick_idx];
          ptyp_d  = req_par_typ[pick_idx];
          gid_d   = pick_idx;
          rr_d    = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dv_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Busy seen even if stale counts as acknowledge.
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      gid_q   <= '0;
      rdy_q   <= '0;
      data_q  <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = rdy_q;
  assign tx_p_data     = data_q;
  assign tx_data_valid = dv_q;
  assign tx_par_en     = pen_q;
  assign tx_par_typ    = ptyp_q;
  assign grant_id      = gid_q;
  assign arb_busy      = busy_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: arbiter driving a behavioural UART transmitter,
// with a line receiver decoding the serial frames.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_par_en;
  logic [3:0]  req_par_typ;
  logic [3:0]  req_ready;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        tx_par_en;
  logic        tx_par_typ;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .ACK_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_par_en    (req_par_en),
    .req_par_typ   (req_par_typ),
    .req_ready     (req_ready),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .tx_par_en     (tx_par_en),
    .tx_par_typ    (tx_par_typ),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural UART_TX: one bit per clock, start/data LSB first/parity/stop.
  logic        nack;
  logic        stale;
  logic        mdl_busy;
  logic        mdl_par_en;
  logic        tx_line;
  logic [10:0] mdl_sh;
  int          mdl_left;

  assign tx_busy = nack ? 1'b0 : (mdl_busy | stale);

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0;
      tx_line  <= 1'b1;
      mdl_left <= 0;
    end else if (mdl_left > 0) begin
      tx_line  <= mdl_sh[0];
      mdl_sh   <= {1'b1, mdl_sh[10:1]};
      mdl_left <= mdl_left - 1;
    end else if (tx_data_valid && !nack) begin
      mdl_sh     <= tx_par_en ?
                    {1'b1, ^tx_p_data ^ tx_par_typ, tx_p_data, 1'b0} :
                    {2'b11, tx_p_data, 1'b0};
      mdl_left   <= tx_par_en ? 11 : 10;
      mdl_par_en <= tx_par_en;
      mdl_busy   <= 1'b1;
    end else begin
      mdl_busy <= 1'b0;
      tx_line  <= 1'b1;
    end
  end

  // Line receiver.
  logic [7:0] rx_sh;
  logic       rx_par;
  logic       rx_act;
  int         rx_i;
  logic [7:0] rx_data_q [$];
  logic       rx_par_q  [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx_line == 1'b0) begin
        rx_act = 1'b1;
        rx_i   = 0;
        rx_sh  = '0;
        rx_par = 1'b0;
      end
    end else begin
      if (rx_i < 8) begin
        rx_sh[rx_i] = tx_line;
      end else if (mdl_par_en && rx_i == 8) begin
        rx_par = tx_line;
      end else begin
        rx_data_q.push_back(rx_sh);
        rx_par_q.push_back(rx_par);
        rx_act = 1'b0;
      end
      rx_i++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    req_valid   = '0;
    req_par_en  = '0;
    req_par_typ = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_data_q.delete();
    rx_par_q.delete();
  endtask

  task automatic get_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (req_ready == (4'b0001 << i)) idx = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((arb_busy || tx_busy || rx_act) && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= 200) begin
      errors++;
      $display("FAIL %s: idle wait expired, arb_busy=%b required 0", name, arb_busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 6;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b want 0", tx_data_valid); end
    if (tx_p_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", tx_p_data); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", arb_busy); end
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_timeout); end
  endtask

  task automatic test_single();
    apply_reset();
    req_data[7:0] = 8'hA5;
    req_par_en    = 4'b0001;
    req_par_typ   = 4'b0000;
    req_valid     = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    checks += 3;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL single_dv_early: got %b want 0", tx_data_valid); end
    if (arb_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", arb_busy); end
    @(negedge clk);
    checks += 4;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse: got %b want 0000", req_ready); end
    if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL single_dv: got %b want 1", tx_data_valid); end
    if (tx_p_data !== 8'hA5) begin errors++; $display("FAIL single_pdata: got %h want a5", tx_p_data); end
    if (tx_par_en !== 1'b1) begin errors++; $display("FAIL single_paren: got %b want 1", tx_par_en); end
    wait_idle("single");
    checks += 3;
    if (rx_data_q.size() !== 1) begin
      errors++; $display("FAIL single_frames: got %0d want 1", rx_data_q.size());
    end else begin
      if (rx_data_q[0] !== 8'hA5) begin errors++; $display("FAIL single_line: got %h want a5", rx_data_q[0]); end
      if (rx_par_q[0] !== 1'b0) begin errors++; $display("FAIL single_par: got %b want 0", rx_par_q[0]); end
    end
  endtask

  task automatic test_simultaneous();
    int g;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    apply_reset();
    req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      get_grant(g);
      if (n == 4) req_valid = 4'b0000;
      checks += 2;
      if (g != exp_g[n]) begin errors++; $display("FAIL sim_grant%0d: got %0d want %0d", n, g, exp_g[n]); end
      if (grant_id !== 2'(exp_g[n])) begin errors++; $display("FAIL sim_gid%0d: got %0d want %0d", n, grant_id, exp_g[n]); end
    end
    wait_idle("sim");
    checks++;
    if (rx_data_q.size() !== 5) begin
      errors++; $display("FAIL sim_frames: got %0d want 5", rx_data_q.size());
    end else begin
      for (int n = 0; n < 5; n++) begin
        checks++;
        if (rx_data_q[n] !== exp_d[n]) begin errors++; $display("FAIL sim_line%0d: got %h want %h", n, rx_data_q[n], exp_d[n]); end
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    apply_reset();
    req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
    req_valid = 4'b0010;
    get_grant(g);
    req_valid = 4'b0000;
    wait_idle("fair_prime");
    req_valid = 4'b1010;
    get_grant(g);
    checks++;
    if (g != 3) begin errors++; $display("FAIL fair_first: got %0d want 3", g); end
    get_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g != 1) begin errors++; $display("FAIL fair_second: got %0d want 1", g); end
    wait_idle("fair");
  endtask

  task automatic test_timeout();
    int g;
    int k;
    apply_reset();
    nack          = 1'b1;
    req_data[7:0] = 8'h5A;
    req_valid     = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    k = 0;
    while (!tx_data_valid && k < 10) begin @(negedge clk); k++; end
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (err_timeout) break;
    end
    checks += 2;
    if (k != 5) begin errors++; $display("FAIL to_delay: got %0d want 5", k); end
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", arb_busy); end
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", err_timeout); end
    nack           = 1'b0;
    req_data[23:16] = 8'h77;
    req_valid      = 4'b0100;
    get_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g != 2) begin errors++; $display("FAIL to_next_grant: got %0d want 2", g); end
    wait_idle("to");
    checks++;
    if (rx_data_q.size() !== 1 || rx_data_q[0] !== 8'h77) begin
      errors++; $display("FAIL to_next_line: got %0d frames want 1 of 77", rx_data_q.size());
    end
  endtask

  task automatic test_stale();
    int k;
    int errs_seen;
    apply_reset();
    stale         = 1'b1;
    req_data[7:0] = 8'h3C;
    req_valid     = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL stale_dv: got %b want 1", tx_data_valid); end
    errs_seen = 0;
    for (k = 0; k < 8; k++) begin
      @(negedge clk);
      if (err_timeout) errs_seen++;
    end
    stale = 1'b0;
    checks++;
    if (errs_seen != 0) begin errors++; $display("FAIL stale_err: got %0d pulses want 0", errs_seen); end
    wait_idle("stale");
  endtask

  task automatic test_reset_mid();
    int g;
    int k;
    apply_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b0011;
    get_grant(g);
    k = 0;
    while (!tx_busy && k < 20) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", arb_busy); end
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    if (tx_p_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h want 00", tx_p_data); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_gid: got %0d want 0", grant_id); end
    if (tx_par_en !== 1'b0 || tx_data_valid !== 1'b0) begin
      errors++; $display("FAIL mid_tx: got paren=%b dv=%b want 0 0", tx_par_en, tx_data_valid);
    end
    rst_n = 1'b1;
    rx_data_q.delete();
    rx_par_q.delete();
    get_grant(g);
    req_valid = 4'b0000;
    checks++;
    if (g != 0) begin errors++; $display("FAIL mid_regrant: got %0d want 0", g); end
    wait_idle("mid");
  endtask

  task automatic test_parity();
    apply_reset();
    req_data[23:16] = 8'h03;
    req_par_en      = 4'b0100;
    req_par_typ     = 4'b0100;
    req_valid       = 4'b0100;
    @(negedge clk);
    req_valid = 4'b0000;
    wait_idle("par");
    checks++;
    if (rx_data_q.size() !== 1) begin
      errors++; $display("FAIL par_frames: got %0d want 1", rx_data_q.size());
    end else begin
      checks += 2;
      if (rx_data_q[0] !== 8'h03) begin errors++; $display("FAIL par_line: got %h want 03", rx_data_q[0]); end
      if (rx_par_q[0] !== 1'b1) begin errors++; $display("FAIL par_bit: got %b want 1", rx_par_q[0]); end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    req_par_en  = '0;
    req_par_typ = '0;
    nack        = 1'b0;
    stale       = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_stale();
    test_reset_mid();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
